// File: rtl/reg_writeback.sv
// Register-file write side: a result FIFO that drains one register per cycle into the
// write port, plus a per-register pending-write scoreboard for decode stalls.
module reg_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_res_valid,
    output logic        o_res_ready,
    input  logic        i_res_regwrite,
    input  logic [5:0]  i_res_rd,
    input  logic [31:0] i_res_alu,
    input  logic [31:0] i_res_mem,
    input  logic        i_res_memtoreg,
    input  logic        i_iss_valid,
    input  logic [5:0]  i_iss_rd,
    input  logic [5:0]  i_qs,
    input  logic [5:0]  i_qt,
    output logic        o_busy_s,
    output logic        o_busy_t,
    input  logic        i_wb_hold,
    output logic [5:0]  o_wb_rd,
    output logic [31:0] o_wb_din,
    output logic        o_wb_wrt,
    output logic        o_sb_err
);

    localparam int unsigned RW   = 6;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 64;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

    wb_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_wb_wrt;
    logic [RW-1:0]    r_wb_rd;
    logic [DW-1:0]    r_wb_din;
    logic [1:0]       r_cnt [NREG];
    logic             r_sb_err;

    logic             w_push;
    logic             w_pop;
    wb_entry_t        w_entry;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;
    logic [1:0]       w_cnt_nxt [NREG];
    logic             w_err_set;

    // Readiness depends only on occupancy, so a full FIFO refuses even while popping.
    assign o_res_ready = (r_count < CW'(DEPTH));
    assign w_push      = i_res_valid && o_res_ready && i_res_regwrite && (i_res_rd != '0);
    assign w_pop       = !i_wb_hold && (r_count != '0);
    assign w_entry.rd   = i_res_rd;
    assign w_entry.data = i_res_memtoreg ? i_res_mem : i_res_alu;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Write port: address/data hold their last value when no write is issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_wrt <= 1'b0;
            r_wb_rd  <= '0;
            r_wb_din <= '0;
        end else if (w_pop) begin
            r_wb_wrt <= 1'b1;
            r_wb_rd  <= r_mem[r_rd_ptr].rd;
            r_wb_din <= r_mem[r_rd_ptr].data;
        end else begin
            r_wb_wrt <= 1'b0;
        end
    end

    assign o_wb_wrt = r_wb_wrt;
    assign o_wb_rd  = r_wb_rd;
    assign o_wb_din = r_wb_din;

    assign w_inc = (i_iss_valid && (i_iss_rd != '0)) ? (NREG'(1) << i_iss_rd) : '0;
    assign w_dec = r_wb_wrt ? (NREG'(1) << r_wb_rd) : '0;

    // Saturating scoreboard counters; simultaneous inc/dec of one register cancel.
    always_comb begin
        w_err_set    = 1'b0;
        w_cnt_nxt[0] = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_inc[i] && !w_dec[i]) begin
                if (r_cnt[i] == 2'd3) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 2'd1;
                end
            end else if (w_dec[i] && !w_inc[i]) begin
                if (r_cnt[i] == 2'd0) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_sb_err <= r_sb_err | w_err_set;
        end
    end

    // Counter 0 is pinned to zero, so querying register 0 never reports busy.
    assign o_busy_s = (r_cnt[i_qs] != 2'd0);
    assign o_busy_t = (r_cnt[i_qt] != 2'd0);
    assign o_sb_err = r_sb_err;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus random traffic, all checked against
// a queue/array reference model updated once per clock edge.
module tb_reg_writeback;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic        res_regwrite;
    logic [5:0]  res_rd;
    logic [31:0] res_alu;
    logic [31:0] res_mem;
    logic        res_memtoreg;
    logic        iss_valid;
    logic [5:0]  iss_rd;
    logic [5:0]  qs;
    logic [5:0]  qt;
    logic        busy_s;
    logic        busy_t;
    logic        wb_hold;
    logic [5:0]  wb_rd;
    logic [31:0] wb_din;
    logic        wb_wrt;
    logic        sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [37:0] m_q [$];
    int          m_cnt [64];
    logic        m_wrt;
    logic [5:0]  m_rd;
    logic [31:0] m_din;
    logic        m_err;

    logic [5:0]  seq [$];

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_res_valid    (res_valid),
        .o_res_ready    (res_ready),
        .i_res_regwrite (res_regwrite),
        .i_res_rd       (res_rd),
        .i_res_alu      (res_alu),
        .i_res_mem      (res_mem),
        .i_res_memtoreg (res_memtoreg),
        .i_iss_valid    (iss_valid),
        .i_iss_rd       (iss_rd),
        .i_qs           (qs),
        .i_qt           (qt),
        .o_busy_s       (busy_s),
        .o_busy_t       (busy_t),
        .i_wb_hold      (wb_hold),
        .o_wb_rd        (wb_rd),
        .o_wb_din       (wb_din),
        .o_wb_wrt       (wb_wrt),
        .o_sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int r = 0; r < 64; r++) m_cnt[r] = 0;
        m_wrt = 1'b0;
        m_rd  = '0;
        m_din = '0;
        m_err = 1'b0;
    endtask

    // One clock edge of the architectural behaviour, using pre-edge state and inputs.
    task automatic model_edge();
        int         sz      = m_q.size();
        logic       old_wrt = m_wrt;
        logic [5:0] old_rd  = m_rd;
        bit         push    = res_valid && (sz < DEPTH) && res_regwrite && (res_rd != 0);
        if (!wb_hold && sz > 0) begin
            {m_rd, m_din} = m_q.pop_front();
            m_wrt = 1'b1;
        end else begin
            m_wrt = 1'b0;
        end
        if (push) m_q.push_back({res_rd, res_memtoreg ? res_mem : res_alu});
        for (int r = 1; r < 64; r++) begin
            int d = ((iss_valid && iss_rd == 6'(r)) ? 1 : 0) - ((old_wrt && old_rd == 6'(r)) ? 1 : 0);
            if (d > 0) begin
                if (m_cnt[r] == 3) m_err = 1'b1; else m_cnt[r]++;
            end else if (d < 0) begin
                if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
            end
        end
    endtask

    task automatic check_all();
        check_eq("wb_wrt", 32'(wb_wrt), 32'(m_wrt));
        check_eq("wb_rd", 32'(wb_rd), 32'(m_rd));
        check_eq("wb_din", wb_din, m_din);
        check_eq("res_ready", 32'(res_ready), 32'(m_q.size() < DEPTH));
        check_eq("busy_s", 32'(busy_s), 32'(qs != 0 && m_cnt[qs] != 0));
        check_eq("busy_t", 32'(busy_t), 32'(qt != 0 && m_cnt[qt] != 0));
        check_eq("sb_err", 32'(sb_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (wb_wrt) seq.push_back(wb_rd);
    endtask

    task automatic idle();
        res_valid = 0; res_regwrite = 0; res_rd = 0; res_alu = 0; res_mem = 0;
        res_memtoreg = 0; iss_valid = 0; iss_rd = 0;
    endtask

    task automatic drive_res(input logic [5:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                             input logic m2r, input logic issue);
        res_valid = 1; res_regwrite = 1; res_rd = rd; res_alu = alu; res_mem = mem;
        res_memtoreg = m2r; iss_valid = issue; iss_rd = rd;
    endtask

    // Asynchronous reset asserted between edges, held over one edge, released after it.
    task automatic mid_reset(input string tag);
        #3;
        rst = 1;
        #1;
        check_eq({tag, "_wrt"}, 32'(wb_wrt), 32'd0);
        check_eq({tag, "_ready"}, 32'(res_ready), 32'd1);
        check_eq({tag, "_busy_s"}, 32'(busy_s), 32'd0);
        check_eq({tag, "_err"}, 32'(sb_err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        clk = 0; rst = 0; wb_hold = 0; qs = 0; qt = 0;
        idle();
        #1 rst = 1;
        #1;
        check_eq("rst_wrt", 32'(wb_wrt), 32'd0);
        check_eq("rst_rd", 32'(wb_rd), 32'd0);
        check_eq("rst_din", wb_din, 32'd0);
        check_eq("rst_err", 32'(sb_err), 32'd0);
        check_eq("rst_ready", 32'(res_ready), 32'd1);
        check_eq("rst_busy_s", 32'(busy_s), 32'd0);
        check_eq("rst_busy_t", 32'(busy_t), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;

        // Single ALU result, latency 2 edges; busy clears at the commit edge
        qs = 5;
        drive_res(6'd5, 32'h1234, 32'h0, 1'b0, 1'b1);
        step();
        check_eq("lat_e1_wrt", 32'(wb_wrt), 32'd0);
        check_eq("lat_e1_busy", 32'(busy_s), 32'd1);
        idle();
        step();
        check_eq("lat_e2_wrt", 32'(wb_wrt), 32'd1);
        check_eq("lat_e2_rd", 32'(wb_rd), 32'd5);
        check_eq("lat_e2_din", wb_din, 32'h00001234);
        check_eq("lat_e2_busy", 32'(busy_s), 32'd1);
        step();
        check_eq("lat_e3_wrt", 32'(wb_wrt), 32'd0);
        check_eq("lat_e3_busy", 32'(busy_s), 32'd0);

        // Load data selection
        drive_res(6'd6, 32'h1, 32'hDEADBEEF, 1'b1, 1'b1);
        step();
        idle();
        step();
        check_eq("m2r_din", wb_din, 32'hDEADBEEF);
        step();

        // Dropped results: rd 0 and regwrite 0
        seq.delete();
        drive_res(6'd0, 32'hAAAA, 32'h0, 1'b0, 1'b0);
        check_eq("drop_ready0", 32'(res_ready), 32'd1);
        step();
        drive_res(6'd8, 32'hBBBB, 32'h0, 1'b0, 1'b0);
        res_regwrite = 0;
        check_eq("drop_ready1", 32'(res_ready), 32'd1);
        step();
        idle();
        repeat (3) step();
        check_eq("drop_no_write", 32'(seq.size()), 32'd0);

        // Hold fills the FIFO; release drains in order
        wb_hold = 1;
        for (int k = 1; k <= 4; k++) begin
            drive_res(6'(k), 32'(k * 16'h111), 32'h0, 1'b0, 1'b1);
            step();
        end
        check_eq("full_ready", 32'(res_ready), 32'd0);
        drive_res(6'd5, 32'h555, 32'h0, 1'b0, 1'b1);
        step();
        iss_valid = 0;
        step();
        check_eq("hold_wrt", 32'(wb_wrt), 32'd0);
        seq.delete();
        wb_hold = 0;
        step();
        check_eq("pop_ready", 32'(res_ready), 32'd1);
        step();
        idle();
        repeat (4) step();
        check_eq("order_len", 32'(seq.size()), 32'd5);
        for (int k = 0; k < 5 && k < seq.size(); k++) check_eq("order_rd", 32'(seq[k]), 32'(k + 1));

        // Scoreboard: issue, commit, and issue in the commit edge
        qs = 7; qt = 0;
        iss_valid = 1; iss_rd = 7;
        step();
        check_eq("sb_issue", 32'(busy_s), 32'd1);
        drive_res(6'd7, 32'h77, 32'h0, 1'b0, 1'b0);
        step();
        idle();
        step();
        iss_valid = 1; iss_rd = 7;
        step();
        check_eq("sb_same_edge", 32'(busy_s), 32'd1);
        check_eq("sb_qt0", 32'(busy_t), 32'd0);
        drive_res(6'd7, 32'h78, 32'h0, 1'b0, 1'b0);
        step();
        idle();
        step();
        step();
        check_eq("sb_clear", 32'(busy_s), 32'd0);
        check_eq("sb_err_clean", 32'(sb_err), 32'd0);

        // Commit with zero count sets the sticky error
        drive_res(6'd10, 32'h10, 32'h0, 1'b0, 1'b0);
        step();
        idle();
        step();
        step();
        check_eq("underflow_err", 32'(sb_err), 32'd1);
        step();
        check_eq("underflow_sticky", 32'(sb_err), 32'd1);

        // Reset with entries queued and a write in progress
        wb_hold = 1; qs = 12;
        for (int k = 11; k <= 14; k++) begin
            drive_res(6'(k), 32'(k), 32'h0, 1'b0, 1'b1);
            step();
        end
        idle();
        wb_hold = 0;
        step();
        check_eq("pre_rst_wrt", 32'(wb_wrt), 32'd1);
        check_eq("pre_rst_busy", 32'(busy_s), 32'd1);
        mid_reset("midrst");
        seq.delete();
        repeat (4) step();
        check_eq("post_rst_writes", 32'(seq.size()), 32'd0);

        // Overflow: four issues to one register
        qs = 9;
        iss_valid = 1; iss_rd = 9;
        repeat (3) step();
        check_eq("sat3_err", 32'(sb_err), 32'd0);
        step();
        check_eq("sat4_err", 32'(sb_err), 32'd1);
        check_eq("sat4_busy", 32'(busy_s), 32'd1);
        idle();
        mid_reset("rst2");

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            res_valid    = ($urandom_range(0, 99) < 60);
            res_regwrite = ($urandom_range(0, 99) < 85);
            res_rd       = 6'($urandom_range(0, 9));
            res_alu      = $urandom;
            res_mem      = $urandom;
            res_memtoreg = 1'($urandom);
            iss_valid    = ($urandom_range(0, 99) < 40);
            iss_rd       = 6'($urandom_range(0, 9));
            wb_hold      = ($urandom_range(0, 99) < 25);
            qs           = 6'($urandom_range(0, 9));
            qt           = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 399) == 0) mid_reset("rnd_rst");
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
